// File: rtl/mux_nx1_pipe.sv
// rtl/mux_nx1_pipe.sv - registered N:1 mux with valid/ready handshake; optional skid buffer via MUX_SKID_EN
module mux_nx1_pipe #(
    parameter int                 WIDTH       = 5,
    parameter int                 NUM_IN      = 3,
    parameter int                 SEL_W       = 2,
    parameter logic [WIDTH-1:0]   DEFAULT_VAL = '0,
    parameter int                 ERR_CNT_W   = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_IN*WIDTH-1:0] in_bus,
    input  logic [SEL_W-1:0]        sel,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    input  logic                    err_clr,
    output logic                    sel_err,
    output logic [ERR_CNT_W-1:0]    err_cnt
);

    logic             accept;
    logic             sel_oor;
    logic [WIDTH-1:0] sel_val;

    // Select the addressed input; anything beyond the last input yields the default value
    always_comb begin
        sel_val = DEFAULT_VAL;
        for (int k = 0; k < NUM_IN; k++) begin
            if (sel == SEL_W'(k)) begin
                sel_val = in_bus[k*WIDTH +: WIDTH];
            end
        end
    end

    // Constant-false when every select code maps to an input, so the error logic folds away
    assign sel_oor = (32'(sel) >= NUM_IN);
    assign accept  = in_valid && in_ready;

`ifdef MUX_SKID_EN
    logic [WIDTH-1:0] skid_data;
    logic             skid_valid;

    // Ready depends only on the skid register, breaking the out_ready-to-in_ready path
    assign in_ready = !skid_valid;

    // Output stage plus one-entry skid; an accept can only happen while skid is empty
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data   <= '0;
            out_valid  <= 1'b0;
            skid_data  <= '0;
            skid_valid <= 1'b0;
        end else if (accept) begin
            if (out_valid && !out_ready) begin
                skid_data  <= sel_val;
                skid_valid <= 1'b1;
            end else begin
                out_data  <= sel_val;
                out_valid <= 1'b1;
            end
        end else if (skid_valid && out_ready) begin
            out_data   <= skid_data;
            skid_valid <= 1'b0;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end
`else
    // Ready when the output register is empty or is being consumed this cycle
    assign in_ready = !out_valid || out_ready;

    // Single output register: load on accept, drop valid when drained without a refill
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data  <= '0;
            out_valid <= 1'b0;
        end else if (accept) begin
            out_data  <= sel_val;
            out_valid <= 1'b1;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end
`endif

    // Sticky error flag and saturating counter; a new error takes priority over a clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_err <= 1'b0;
            err_cnt <= '0;
        end else if (accept && sel_oor) begin
            sel_err <= 1'b1;
            if (err_clr) begin
                err_cnt <= ERR_CNT_W'(1);
            end else if (!(&err_cnt)) begin
                err_cnt <= err_cnt + ERR_CNT_W'(1);
            end
        end else if (err_clr) begin
            sel_err <= 1'b0;
            err_cnt <= '0;
        end
    end

endmodule

// File: tb/tb_mux_nx1_pipe.sv
// tb/tb_mux_nx1_pipe.sv - scoreboard bench for mux_nx1_pipe
module tb_mux_nx1_pipe;

    localparam int W  = 5;
    localparam int N  = 3;
    localparam int SW = 2;
    localparam int CW = 8;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N*W-1:0]  in_bus;
    logic [SW-1:0]   sel;
    logic            in_valid;
    logic            in_ready;
    logic [W-1:0]    out_data;
    logic            out_valid;
    logic            out_ready;
    logic            err_clr;
    logic            sel_err;
    logic [CW-1:0]   err_cnt;

    int total = 0;
    int bad   = 0;

    logic [W-1:0] ins [N];
    logic [W-1:0] exp_q [$];
    int           m_err;
    int           m_cnt;

    always #5 clk = ~clk;

    mux_nx1_pipe #(.WIDTH(W), .NUM_IN(N), .SEL_W(SW), .DEFAULT_VAL('0), .ERR_CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .in_bus(in_bus), .sel(sel), .in_valid(in_valid),
        .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .err_clr(err_clr), .sel_err(sel_err), .err_cnt(err_cnt)
    );

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] ref_pick(input int s);
        if (s < N) return ins[s];
        return '0;
    endfunction

    task automatic pack_bus();
        for (int k = 0; k < N; k++) in_bus[k*W +: W] = ins[k];
    endtask

    // One cycle of stimulus: verify error state from the previous edge, drive, then record an accept
    task automatic drive(input logic iv, input int s, input logic ordy, input logic clr);
        @(negedge clk);
        check("sel_err", int'(sel_err), m_err);
        check("err_cnt", int'(err_cnt), m_cnt);
        pack_bus();
        in_valid  = iv;
        sel       = SW'(s);
        out_ready = ordy;
        err_clr   = clr;
        #1;
        if (iv && in_ready) begin
            exp_q.push_back(ref_pick(s));
            if (s >= N) begin
                m_err = 1;
                m_cnt = clr ? 1 : ((m_cnt == (1 << CW) - 1) ? m_cnt : m_cnt + 1);
            end else if (clr) begin
                m_err = 0;
                m_cnt = 0;
            end
        end else if (clr) begin
            m_err = 0;
            m_cnt = 0;
        end
    endtask

    // Monitor: every transfer that happens on the coming edge must match the oldest expected value
    always @(negedge clk) begin
        #3;
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL out_extra: got data %0d expected no transfer at %0t", out_data, $time);
            end else begin
                check("out_data", int'(out_data), int'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; sel = '0; out_ready = 1'b0; err_clr = 1'b0;
        ins[0] = 5'd3; ins[1] = 5'd10; ins[2] = 5'd21;
        pack_bus();
        m_err = 0; m_cnt = 0;
        #12;
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_data", int'(out_data), 0);
        check("rst_in_ready", int'(in_ready), 1);
        check("rst_sel_err", int'(sel_err), 0);
        check("rst_err_cnt", int'(err_cnt), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // basic select 0,1,2 back to back
        drive(1, 0, 1, 0);
        drive(1, 1, 1, 0);
        check("basic_valid1", int'(out_valid), 1);
        drive(1, 2, 1, 0);
        check("basic_valid2", int'(out_valid), 1);
        drive(0, 0, 1, 0);
        check("basic_valid3", int'(out_valid), 1);
        drive(0, 0, 1, 0);
        check("basic_drained", int'(out_valid), 0);

        // out-of-range then saturation
        drive(1, 3, 1, 0);
        drive(0, 0, 1, 0);
        check("oor_cnt1", int'(err_cnt), 1);
        for (int i = 0; i < 300; i++) drive(1, 3, 1, 0);
        drive(0, 0, 1, 0);
        check("sat_cnt", int'(err_cnt), 255);

        // clear colliding with an error accept, then clear alone
        drive(1, 3, 1, 1);
        drive(0, 0, 1, 1);
        check("clr_coll_cnt", int'(err_cnt), 1);
        check("clr_coll_err", int'(sel_err), 1);
        drive(0, 0, 1, 0);
        check("clr_cnt", int'(err_cnt), 0);
        check("clr_err", int'(sel_err), 0);

        // stall with pending upstream data
        drive(1, 1, 1, 0);
        for (int i = 0; i < 4; i++) begin
            drive(1, 2, 0, 0);
            check("stall_data", int'(out_data), 10);
            check("stall_valid", int'(out_valid), 1);
`ifndef MUX_SKID_EN
            check("stall_ready", int'(in_ready), 0);
`endif
        end
`ifndef MUX_SKID_EN
        drive(1, 2, 1, 0);
`endif
        drive(0, 0, 1, 0);
        check("stall_next", int'(out_data), 21);
        check("stall_next_v", int'(out_valid), 1);
        drive(0, 0, 1, 0);
        drive(0, 0, 1, 0);
        check("stall_q_empty", exp_q.size(), 0);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            for (int k = 0; k < N; k++) ins[k] = W'($urandom);
            drive(1'($urandom_range(0, 3) != 0), int'($urandom_range(0, 3)),
                  1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 15) == 0));
        end
        for (int i = 0; i < 4; i++) drive(0, 0, 1, 0);
        check("rand_q_empty", exp_q.size(), 0);

        // asynchronous reset during a stall
        drive(1, 3, 1, 0);
        drive(1, 1, 0, 0);
        drive(0, 0, 0, 0);
        check("pre_rst_valid", int'(out_valid), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_valid", int'(out_valid), 0);
        check("async_data", int'(out_data), 0);
        check("async_cnt", int'(err_cnt), 0);
        check("async_err", int'(sel_err), 0);
        check("async_ready", int'(in_ready), 1);
        exp_q.delete();
        m_err = 0; m_cnt = 0;
        @(negedge clk);
        rst_n = 1'b1;
        drive(1, 2, 1, 0);
        drive(0, 0, 1, 0);
        drive(0, 0, 1, 0);
        check("post_rst_q_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mux_nx1_pipe.md
Name: mux_nx1_pipe

Overview:
- Parametrised, registered N:1 multiplexer with a valid/ready handshake on both sides. It generalises the fixed 3-input 5-bit selector used in the miniRISC datapath.
- Typical uses: register-destination select, ALU-operand select and write-back select, where a pipeline stage boundary is needed at the mux output.
- Out-of-range selects return a programmable default value. They also raise a sticky error flag and increment a saturating error counter.

Parameters:
- WIDTH, 5, data width of each input and of the output.
- NUM_IN, 3, number of inputs (2..16).
- SEL_W, 2, select width; must satisfy 2**SEL_W >= NUM_IN.
- DEFAULT_VAL, 0, value (WIDTH bits) output when sel >= NUM_IN.
- ERR_CNT_W, 8, width of the saturating error counter.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_bus  input  NUM_IN*WIDTH  packed inputs; input k occupies bits [k*WIDTH +: WIDTH].
- sel  input  SEL_W  input select, sampled with in_valid.
- in_valid  input  1  upstream offers in_bus/sel.
- in_ready  output  1  block can accept this cycle.
- out_data  output  WIDTH  registered selected value.
- out_valid  output  1  out_data holds an unconsumed result.
- out_ready  input  1  downstream accepts out_data.
- err_clr  input  1  synchronous clear of sel_err and err_cnt.
- sel_err  output  1  sticky: an out-of-range select has been accepted.
- err_cnt  output  ERR_CNT_W  saturating count of accepted out-of-range selects.

Behaviour:
- Reset (rst_n low, asynchronous): out_data=0, out_valid=0, sel_err=0, err_cnt=0. Any in-flight or stalled data is discarded. in_ready=1 while out_valid=0.
- Accept: accept = in_valid && in_ready.
- Ready (without MUX_SKID_EN): in_ready = !out_valid || out_ready. This is a combinational path from out_ready.
- On accept:
  - out_data <= in_bus[sel*WIDTH +: WIDTH] if sel < NUM_IN, else DEFAULT_VAL.
  - out_valid <= 1.
- Latency: one cycle from accept to out_valid.
- Throughput: one transfer per cycle while out_ready=1.
- Drain: if out_valid && out_ready && !accept, then out_valid <= 0. out_data keeps its last value; it is don't-care when invalid.
- Stall: while out_valid && !out_ready, out_data and out_valid stay stable (no change) and in_ready=0.
- Handshake rules:
  - Upstream must hold in_bus/sel stable while in_valid && !in_ready.
  - sel and in_bus are ignored when no accept occurs.
- Error tracking, updated only on accept with sel >= NUM_IN:
  - sel_err <= 1.
  - err_cnt increments and saturates at all-ones; it never wraps.
- err_clr in the same cycle as an error accept: the error wins. sel_err=1 and err_cnt=1.
- err_clr alone: sel_err=0 and err_cnt=0 on the next edge.
- When NUM_IN == 2**SEL_W, the error logic is constant: sel_err stays 0 and err_cnt stays 0.

Optional Feature:
- Macro: MUX_SKID_EN.
- When defined:
  - A one-entry skid register (skid_data, skid_valid) is added, and in_ready = !skid_valid becomes a registered signal.
  - If an accept occurs while out_valid && !out_ready, the selected value goes into skid, and skid_valid <= 1.
  - When out_ready is seen with skid_valid=1: out_data <= skid_data, skid_valid <= 0, out_valid stays 1.
  - Ordering is strictly preserved. Full throughput is kept with no combinational out_ready-to-in_ready path.
  - Error logic is evaluated at accept time, not at skid drain.
  - Reset clears skid_valid.
- When undefined: no skid storage; in_ready follows the combinational rule above.

Test Plan:
- Basic select: WIDTH=5, NUM_IN=3, in_bus={5'd21,5'd10,5'd3}, out_ready=1. Drive sel=0,1,2 with in_valid=1 on consecutive cycles -> out_data 3,10,21 one cycle later each; out_valid continuous; sel_err=0.
- Out-of-range: sel=3, in_valid=1 -> out_data=DEFAULT_VAL(0), sel_err=1, err_cnt=1. Repeat 300 times with ERR_CNT_W=8 -> err_cnt saturates at 255.
- Stall: accept sel=1 (10), then hold out_ready=0 for 4 cycles while in_valid=1 with sel=2 -> out_data stays 10, in_ready=0 (no skid). Release out_ready -> 10 is consumed, then 21 appears the next cycle.
- Clear collision: err_clr=1 in the same cycle as an accept with sel=3 -> sel_err=1, err_cnt=1. err_clr alone the next cycle -> both 0.
- Reset mid-stall: out_valid=1, out_ready=0, assert rst_n=0 asynchronously between edges -> out_valid=0, out_data=0, err_cnt=0 immediately, without waiting for a clock edge.
- MUX_SKID_EN: out_ready=0 with out holding 3; accept sel=1 -> skid holds 10 and in_ready=0 next cycle. Raise out_ready -> outputs 3 then 10 in order with no bubble; in_ready returns to 1.
